// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    localparam int          XLEN       = 32;
    localparam int          INSN_BYTES = 4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a first-word-fall-through head.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; flush takes priority over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_do_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
            r_wr_ptr <= w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited imem requests, buffers
// responses with their PCs and handles redirects by draining stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            insn_valid,
    input  logic            insn_ready,
    output logic [XLEN-1:0] insn_data,
    output logic [XLEN-1:0] insn_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [OW-1:0]   r_drop_cnt;
    logic [OW-1:0]   w_outstanding;
    logic [FW-1:0]   w_fifo_count;
    logic [XLEN-1:0] w_pcq_head;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head_entry;
    logic            w_fifo_empty;
    logic            w_redirect;
    logic            w_credit_ok;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;

    // Outstanding requests plus buffered entries never exceed the buffer, so
    // every response is guaranteed a slot and is never back-pressured.
    assign w_credit_ok = (32'(w_outstanding) < 32'(MAX_OUTSTANDING)) &&
                         ((32'(w_outstanding) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH));
    assign w_redirect  = redirect_valid && (r_state == FETCH);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_push      = imem_resp_valid && (r_drop_cnt == '0) && !w_redirect;
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_pop       = !w_fifo_empty && insn_ready;
    assign w_push_entry = '{pc: w_pcq_head, insn: imem_resp_data};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign insn_valid     = !w_fifo_empty;
    assign insn_data      = w_fifo_empty ? '0 : w_head_entry.insn;
    assign insn_pc        = w_fifo_empty ? '0 : w_head_entry.pc;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and request-valid decode.
    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                w_state_next = FETCH;
                w_req_valid  = !redirect_valid && w_credit_ok;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // Fetch PC: jumps to the aligned redirect target or advances on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(INSN_BYTES);
        end else begin
            r_fetch_pc <= r_fetch_pc;
        end
    end

    // Every request still in flight after a redirect edge is stale, which
    // already includes any earlier un-drained drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_redirect) begin
            r_drop_cnt <= w_outstanding - OW'(imem_resp_valid);
        end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - OW'(1);
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_queue (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_req_fire),
        .i_data  (r_fetch_pc),
        .i_pop   (imem_resp_valid),
        .i_flush (1'b0),
        .o_head  (w_pcq_head),
        .o_count (w_outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_insn_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_head_entry),
        .o_count (w_fifo_count)
    );
endmodule
